// File: rtl/xalu_arbiter.sv
// xalu_arbiter: round-robin front end that turns whole XALU operations from two requesters
// into the A0/A1 write + result read bus sequence. Optional macro: XALU_ARB_SKIP_EN.
module xalu_arbiter #(
    parameter logic [7:0] BASE_ADDR  = 8'h0F,
    parameter int         data_width = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [3:0]            req0_op,
    input  logic [data_width-1:0] req0_a,
    input  logic [data_width-1:0] req0_b,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [3:0]            req1_op,
    input  logic [data_width-1:0] req1_a,
    input  logic [data_width-1:0] req1_b,
    output logic                  rsp0_valid,
    output logic [data_width-1:0] rsp0_data,
    output logic                  rsp0_err,
    output logic                  rsp1_valid,
    output logic [data_width-1:0] rsp1_data,
    output logic                  rsp1_err,
    output logic [7:0]            xalu_addr,
    output logic                  xalu_write_en,
    output logic [data_width-1:0] xalu_din,
    input  logic [data_width-1:0] xalu_dout,
    output logic                  busy
);
    typedef enum logic [2:0] {IDLE, WR_A0, WR_A1, RD, RSP} state_t;

    state_t                r_state, w_next;
    logic                  r_last, r_id;
    logic [3:0]            r_op;
    logic [data_width-1:0] r_a, r_b, r_data0, r_data1;
    logic                  r_err0, r_err1;
    logic                  w_gnt0, w_gnt1, w_hs, w_id, w_bad_op;
    logic                  w_skip_a0, w_skip_a1;
    logic [3:0]            w_op;

    // r_last names the requester served most recently; a tie goes to the other one
    assign w_gnt0   = (r_state == IDLE) && rst && req0_valid && (!req1_valid || r_last);
    assign w_gnt1   = (r_state == IDLE) && rst && req1_valid && (!req0_valid || !r_last);
    assign w_hs     = w_gnt0 | w_gnt1;
    assign w_id     = w_gnt1;
    assign w_op     = w_gnt1 ? req1_op : req0_op;
    assign w_bad_op = (w_op > 4'd9);

`ifdef XALU_ARB_SKIP_EN
    assign w_skip_a0 = (w_op == 4'd1);
    assign w_skip_a1 = (r_op == 4'd0) || (r_op == 4'd2) || (r_op == 4'd3) || (r_op == 4'd9);
`else
    assign w_skip_a0 = 1'b0;
    assign w_skip_a1 = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_hs) w_next = w_bad_op ? RSP : (w_skip_a0 ? WR_A1 : WR_A0);
            WR_A0:   w_next = w_skip_a1 ? RD : WR_A1;
            WR_A1:   w_next = RD;
            RD:      w_next = RSP;
            RSP:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // response registers change only for the requester being answered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_last  <= 1'b1;
            r_id    <= 1'b0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_data0 <= '0;
            r_data1 <= '0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
        end else begin
            if (w_hs) begin
                r_id   <= w_id;
                r_last <= w_id;
                r_op   <= w_op;
                r_a    <= w_id ? req1_a : req0_a;
                r_b    <= w_id ? req1_b : req0_b;
                if (w_bad_op) begin
                    if (w_id) begin r_data1 <= '0; r_err1 <= 1'b1; end
                    else      begin r_data0 <= '0; r_err0 <= 1'b1; end
                end
            end
            if (r_state == RD) begin
                if (r_id) begin r_data1 <= xalu_dout; r_err1 <= 1'b0; end
                else      begin r_data0 <= xalu_dout; r_err0 <= 1'b0; end
            end
        end
    end

    always_comb begin
        xalu_addr     = 8'h00;
        xalu_write_en = 1'b0;
        xalu_din      = '0;
        case (r_state)
            WR_A0: begin
                xalu_addr     = BASE_ADDR;
                xalu_write_en = 1'b1;
                xalu_din      = r_a;
            end
            WR_A1: begin
                xalu_addr     = BASE_ADDR + 8'd1;
                xalu_write_en = 1'b1;
                xalu_din      = r_b;
            end
            RD:      xalu_addr = BASE_ADDR + {4'd0, r_op};
            default: ;
        endcase
    end

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;
    assign rsp0_valid = (r_state == RSP) && !r_id;
    assign rsp1_valid = (r_state == RSP) && r_id;
    assign rsp0_data  = r_data0;
    assign rsp1_data  = r_data1;
    assign rsp0_err   = r_err0;
    assign rsp1_err   = r_err1;
    assign busy       = (r_state != IDLE);
endmodule
